// File: rtl/uart_tx_param_if.sv
// Producer-side bus for uart_tx_param: write strobe, data word, per-frame
// options and the status returned to the producer.
interface uart_tx_param_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_W-1:0]            data_in;
  logic                         load;
  logic                         two_stop;
  logic                         parity_odd;
  logic                         ready;
  logic                         busy;
  logic                         overflow;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  // Producer side.
  modport master (
    output data_in, load, two_stop, parity_odd,
    input  ready, busy, overflow, fifo_count
  );

  // Transmitter side.
  modport slave (
    input  data_in, load, two_stop, parity_odd,
    output ready, busy, overflow, fifo_count
  );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with TX FIFO.
// One system clock (clk_sis); an internal baud counter times every bit.
// Frame: start, DATA_W data bits LSB first, optional parity, one or two stops.
// Optional feature macro: UART_TX_PARITY_EN inserts the PARITY state
// between DATA and STOP; when undefined, parity_odd is ignored.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk_sis,
  input  logic           rst,
  uart_tx_param_if.slave bus,
  output logic           tx1
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_W - 1);
  localparam logic [CNT_FW-1:0] FULL_COUNT = CNT_FW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_FW-1:0] count_q;
  logic [CNT_FW-1:0] count_d;
  logic              ready_q;
  logic              overflow_q;
  logic              push;
  logic              pop;
  logic              empty;

  // A full FIFO drops the write even if the frame engine pops this cycle,
  // because ready reflects the occupancy before the edge.
  assign push    = bus.load && ready_q;
  assign empty   = (count_q == '0);
  assign count_d = count_q + CNT_FW'(push) - CNT_FW'(pop);

  // Storage write port.
  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers and count, so stale entries are never read.
  always_ff @(posedge clk_sis) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy, registered ready and sticky overflow.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_d;
      ready_q <= (count_d != FULL_COUNT);
      if (bus.load && !ready_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame engine
  // ---------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  baud_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shreg_q;
  logic              two_stop_q;
  logic              tx_d;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  // Last clock of the current bit period; never true while idle.
  assign bit_end = (state_q != S_IDLE) && (baud_q == BAUD_LAST);

  // Next state, FIFO pop and line value for the current state.
  // NOTE: every output of this block gets a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shreg_q[0];
        if (bit_end && (idx_q == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = parity_q;
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        // In STOP the bit index counts stop bits: done after one, or two
        // when the frame latched two_stop.
        if (bit_end && (!two_stop_q || idx_q[0])) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, baud counter, bit index, frame options and the registered line.
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      two_stop_q <= 1'b0;
      tx1        <= 1'b1;
    end else begin
      state_q <= state_d;
      tx1     <= tx_d;
      if ((state_q == S_IDLE) || bit_end) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + 1'b1;
      end
      if (state_d != state_q) begin
        idx_q <= '0;
      end else if (bit_end) begin
        idx_q <= idx_q + 1'b1;
      end
      if (pop) begin
        two_stop_q <= bus.two_stop;
      end
    end
  end

  // Data shifter and parity, loaded from the FIFO head on each pop.
  always_ff @(posedge clk_sis) begin
    if (pop) begin
      shreg_q <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      parity_q <= (^mem[rd_ptr]) ^ bus.parity_odd;
`endif
    end else if ((state_q == S_DATA) && bit_end) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  // Producer-facing status.
  assign bus.ready      = ready_q;
  assign bus.busy       = (state_q != S_IDLE) || (count_q != '0);
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to the single-frame UART1 transmitter. One system clock replaces the separate clk_uart/clk_sis pair: an internal baud counter generates bit timing.
Adds a TX FIFO with a load/ready handshake, configurable data width, runtime selection of one or two stop bits, and optional parity.
Sits between the system-side producer and the serial line tx1.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clk_sis cycles per serial bit; must be >= 2.
FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2.

Ports:
clk_sis  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-low reset.
data_in  input  DATA_W  word to transmit.
load  input  1  write strobe; data_in is pushed when load && ready.
two_stop  input  1  1 = two stop bits; sampled at frame start.
parity_odd  input  1  parity sense, 1 = odd; sampled at frame start. Used only with UART_TX_PARITY_EN.
ready  output  1  FIFO not full (registered).
busy  output  1  frame in progress or FIFO not empty.
overflow  output  1  sticky; set when load is asserted while ready=0.
fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
tx1  output  1  serial line; idles high; registered.

Behaviour:
- Reset (rst=0, takes effect immediately): tx1=1, ready=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, baud counter=0, FIFO emptied. A frame in progress is aborted with no partial stop bit.
- FIFO: push on load && ready. A push when full is dropped and sets overflow; a simultaneous pop does not rescue it. A push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx1=1. If FIFO not empty: pop; latch the word, two_stop and parity_odd; go to START.
  - START: tx1=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_W bits, LSB first, each CLKS_PER_BIT cycles. Bit index counts 0..DATA_W-1.
  - PARITY (present only with the macro): 1 bit. Value = XOR of the data bits, inverted when parity_odd=1.
  - STOP: tx1=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT when latched two_stop=1.
- End of STOP: if the FIFO is not empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Latency: a word loaded at edge N into an empty, idle block drives tx1=0 from edge N+2. The start bit lasts exactly CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and clears on every state/bit transition.
  - Width: $clog2(CLKS_PER_BIT).
  - The counter does not run in IDLE.
- Input changes: two_stop and parity_odd changes mid-frame do not affect the current frame.
- busy = (state != IDLE) || (fifo_count != 0).

Optional Feature:
UART_TX_PARITY_EN — defined: the PARITY state is inserted between DATA and STOP, and the frame grows by one bit. Undefined: no PARITY state, parity_odd is ignored (unconnected internally), and the frame is start + DATA_W + stop(s).

Test Plan:
- Reset mid-frame: DATA_W=8, CLKS_PER_BIT=4; load 0xA5, then pull rst low at cycle 20 -> tx1=1 immediately, fifo_count=0, busy=0. After release the line stays idle.
- Single frame, parity off: load 0xA5, two_stop=0 -> tx1 sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. Start bit appears 2 edges after load; busy drops after 40 cycles.
- Parity and two stop bits, macro defined: load 0xA5, parity_odd=0, two_stop=1 -> parity bit 0, then 8 cycles of stop. With parity_odd=1 the parity bit is 1.
- Back-to-back: load 0x00 and 0xFF on consecutive cycles -> second start bit begins on the cycle after the first stop bit ends. No idle cycles appear between frames.
- FIFO full / overflow: FIFO_DEPTH=4; load 6 words on consecutive cycles while the first frame starts -> 5 accepted (1 popped early), the 6th dropped. ready=0 while full, overflow=1 and stays set. Transmitted order matches the accepted order.
- DATA_W=5, CLKS_PER_BIT=2: load 5'b10011 -> tx1 0,1,1,0,0,1,1, with each bit 2 cycles.
